piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//  Parallel-in/serial-out transmitter: the opposite end of the 6-bit serial-in shift register.
//  Accepts a WIDTH-bit word over a valid/ready handshake and drives it on so, one bit per clk.
//  so connects directly to the receiver's si, so after WIDTH clocks the receiver's s holds the word.
//  Sits between a parallel data source and any serial link.
// PARAMETERS
//  WIDTH       6     bits per word; legal range >= 2
//  MSB_FIRST   1     1: din[WIDTH-1] is sent first; 0: din[0] is sent first
//  IDLE_LEVEL  1'b0  value driven on so whenever so_valid=0
// PORTS
//  clk         in   1      single clock; all state updates on posedge
//  rst_n       in   1      asynchronous, active-low reset
//  din         in   WIDTH  parallel word; sampled only on an accept edge
//  load_valid  in   1      upstream has a word on din
//  load_ready  out  1      serializer can accept a word this cycle
//  so          out  1      serial data out (registered)
//  so_valid    out  1      so carries a data bit this cycle
//  busy        out  1      word in flight (state SHIFT)
//  last        out  1      so carries the final bit of the current word
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, shift reg=0, bit count=0,
//   so=IDLE_LEVEL, so_valid=0, busy=0, last=0. load_ready=1 after release.
//  Accept: posedge with load_valid && load_ready. din is copied into the shift reg.
//  load_ready (combinational) = (state==IDLE) || (state==SHIFT && cnt==WIDTH-1).
//   The second term allows gapless back-to-back words.
//  FSM:
//   IDLE  -> SHIFT on accept.
//   SHIFT -> SHIFT on accept when cnt==WIDTH-1 (cnt reloads to 0).
//   SHIFT -> IDLE when cnt==WIDTH-1 with no accept.
//   Otherwise cnt increments.
//  Latency: word accepted at edge k; bit 0 of the send order is on so during cycle k+1.
//   so_valid=1 for cycles k+1..k+WIDTH exactly; last=1 only in cycle k+WIDTH.
//  Order: MSB_FIRST=1 sends din[WIDTH-1] down to din[0]; MSB_FIRST=0 sends din[0] up to din[WIDTH-1].
//  Counter: $clog2(WIDTH) bits, counts 0..WIDTH-1, wraps to 0. Never exceeds WIDTH-1.
//  Mid-frame: load_valid while load_ready=0 is ignored. Changes on din do not affect the word in flight.
//  Simultaneous last bit and accept: the new word's first bit follows the old word's last bit
//   on the next cycle, with so_valid held at 1.
//  Reset mid-frame: the in-flight word is discarded and outputs go to reset values immediately.
//   There is no partial-word replay.
//  so, so_valid and last are registered outputs (no combinational path from din or load_valid).
// STRUCTURE
//  serial_defs.vh (shared header): state encodings ST_IDLE=1'b0 and ST_SHIFT=1'b1,
//   plus default WIDTH=6 used by both the serializer and the receiver.
//  Sub-module bit_counter: mod-WIDTH up-counter with clear/enable and a terminal-count flag (cnt==WIDTH-1).
//  Top level holds the FSM, the shift register and the output registers.
// TESTING (WIDTH=6, clk period 20ns)
//  1. Hold rst_n=0 for 2 cycles -> so=0, so_valid=0, busy=0, last=0; load_ready=1 after release.
//  2. Load 6'b101001 with MSB_FIRST=1 -> so = 1,0,1,0,0,1 on 6 consecutive cycles;
//     last high on the 6th; so looped into the 6-bit receiver gives s=6'b101001.
//  3. Hold load_valid with 6'b111000 then 6'b010101 -> 12 contiguous so_valid cycles:
//     1,1,1,0,0,0,0,1,0,1,0,1; last high on cycles 6 and 12.
//  4. Mid-frame, set load_valid=1 and din=6'b000000 at bit 2 -> load_ready=0;
//     the remaining bits of the original word are unchanged.
//  5. Assert rst_n=0 during bit 3 -> outputs reset asynchronously (before the next edge);
//     a subsequent load of 6'b110011 serializes cleanly.
//  6. MSB_FIRST=0, load 6'b101001 -> so = 1,0,0,1,0,1.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in/serial-out transmitter and its
// matching serial-in receiver: FSM state encodings and the default word width.
package piso_serializer_pkg;

    localparam int DEFAULT_WIDTH = 6;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Mod-WIDTH up-counter used to track the bit position inside a word.
// Clear has priority over enable; tc flags the final position (WIDTH-1).
module bit_counter
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    // Terminal count marks the last bit position of the current word.
    always_comb begin
        tc = (cnt == CNT_W'(WIDTH - 1));
    end

    // Count 0..WIDTH-1 and wrap; a clear restarts the word at position 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            if (tc) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter. A word accepted over valid/ready is
// driven onto so one bit per clock, starting the cycle after the accept.
// load_ready reopens on the final bit so consecutive words leave no gap.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int   WIDTH      = DEFAULT_WIDTH,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             so,
    output logic             so_valid,
    output logic             busy,
    output logic             last
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   shift_reg;
    logic [CNT_W-1:0]   cnt;
    logic               cnt_tc;
    logic               accept;
    logic               shifting;

    assign accept   = load_valid && load_ready;
    assign shifting = (state == ST_SHIFT);

    bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept),
        .enable (shifting),
        .cnt    (cnt),
        .tc     (cnt_tc)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: start on accept, stay busy across a back-to-back accept.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_tc && !accept) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Handshake and status decode from the current state.
    always_comb begin
        load_ready = (state == ST_IDLE) || ((state == ST_SHIFT) && cnt_tc);
        busy       = (state == ST_SHIFT);
    end

    // Datapath: the first bit goes straight from din to so on accept, and the
    // shift register then feeds the following bits from its next position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            so        <= IDLE_LEVEL;
            so_valid  <= 1'b0;
            last      <= 1'b0;
        end else if (accept) begin
            shift_reg <= din;
            so_valid  <= 1'b1;
            last      <= 1'b0;
            if (MSB_FIRST) begin
                so <= din[WIDTH-1];
            end else begin
                so <= din[0];
            end
        end else if (shifting && !cnt_tc) begin
            so_valid <= 1'b1;
            last     <= (cnt == CNT_W'(WIDTH - 2));
            if (MSB_FIRST) begin
                so        <= shift_reg[WIDTH-2];
                shift_reg <= shift_reg << 1;
            end else begin
                so        <= shift_reg[1];
                shift_reg <= shift_reg >> 1;
            end
        end else begin
            so       <= IDLE_LEVEL;
            so_valid <= 1'b0;
            last     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer (WIDTH=6). Two instances: MSB-first and
// LSB-first. Every accepted word pushes its expected bit stream into a
// scoreboard queue, which is popped once per cycle while checking so.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic [5:0] din_a = '0;
    logic       load_valid_a = 1'b0;
    logic       load_ready_a, so_a, so_valid_a, busy_a, last_a;

    logic [5:0] din_b = '0;
    logic       load_valid_b = 1'b0;
    logic       load_ready_b, so_b, so_valid_b, busy_b, last_b;

    int         checks = 0;
    int         errors = 0;
    bit         sel_b = 1'b0;
    bit         exp_bit_q[$];
    bit         exp_last_q[$];
    logic [5:0] rx_s;

    piso_serializer #(
        .WIDTH      (6),
        .MSB_FIRST  (1'b1),
        .IDLE_LEVEL (1'b0)
    ) dut_msb (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din_a),
        .load_valid (load_valid_a),
        .load_ready (load_ready_a),
        .so         (so_a),
        .so_valid   (so_valid_a),
        .busy       (busy_a),
        .last       (last_a)
    );

    piso_serializer #(
        .WIDTH      (6),
        .MSB_FIRST  (1'b0),
        .IDLE_LEVEL (1'b0)
    ) dut_lsb (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din_b),
        .load_valid (load_valid_b),
        .load_ready (load_ready_b),
        .so         (so_b),
        .so_valid   (so_valid_b),
        .busy       (busy_b),
        .last       (last_b)
    );

    // 20 ns clock.
    initial begin
        forever #10 clk = ~clk;
    end

    // Behavioural 6-bit serial-in receiver looped onto the MSB-first output.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s <= '0;
        end else begin
            rx_s <= {rx_s[4:0], so_a};
        end
    end

    task automatic check1(input string tag, input logic [5:0] obs, input logic [5:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic pushWord(input logic [5:0] w, input bit msb_first);
        for (int i = 0; i < 6; i++) begin
            exp_bit_q.push_back(msb_first ? w[5 - i] : w[i]);
            exp_last_q.push_back(i == 5);
        end
    endtask

    // Compare this cycle's outputs of the selected instance with the scoreboard.
    task automatic checkOutput(input string tag);
        logic m_so, m_valid, m_busy, m_last;
        bit   e_valid, e_bit, e_last;
        m_so    = sel_b ? so_b       : so_a;
        m_valid = sel_b ? so_valid_b : so_valid_a;
        m_busy  = sel_b ? busy_b     : busy_a;
        m_last  = sel_b ? last_b     : last_a;
        e_valid = (exp_bit_q.size() != 0);
        e_bit   = 1'b0;
        e_last  = 1'b0;
        if (e_valid) begin
            e_bit  = exp_bit_q.pop_front();
            e_last = exp_last_q.pop_front();
        end
        check1({tag, "/so_valid"}, 6'(m_valid), 6'(e_valid));
        check1({tag, "/busy"},     6'(m_busy),  6'(e_valid));
        check1({tag, "/so"},       6'(m_so),    6'(e_bit));
        check1({tag, "/last"},     6'(m_last),  6'(e_last));
    endtask

    // One cycle: check outputs at the negedge, then drive the next inputs.
    // Ready is expected exactly when no further bits of a word remain queued.
    task automatic applyStimulus(input string tag, input logic v, input logic [5:0] d,
                                 output bit accepted);
        bit   e_ready;
        logic m_ready;
        @(negedge clk);
        checkOutput(tag);
        e_ready = (exp_bit_q.size() == 0);
        m_ready = sel_b ? load_ready_b : load_ready_a;
        check1({tag, "/load_ready"}, 6'(m_ready), 6'(e_ready));
        if (sel_b) begin
            load_valid_b = v;
            din_b        = d;
        end else begin
            load_valid_a = v;
            din_a        = d;
        end
        accepted = v && e_ready;
        if (accepted) begin
            pushWord(d, !sel_b);
        end
    endtask

    task automatic sendWord(input string tag, input logic [5:0] d);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 20) begin
            applyStimulus(tag, 1'b1, d, acc);
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s accept timeout observed=none required=accept", tag);
        end
    endtask

    task automatic idleCycles(input string tag, input int n);
        bit acc;
        for (int i = 0; i < n; i++) begin
            applyStimulus(tag, 1'b0, 6'b000000, acc);
        end
    endtask

    initial begin
        bit acc;

        // 1. Reset held for two cycles.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check1("rst/so",       6'(so_a),       6'd0);
        check1("rst/so_valid", 6'(so_valid_a), 6'd0);
        check1("rst/busy",     6'(busy_a),     6'd0);
        check1("rst/last",     6'(last_a),     6'd0);
        check1("rst/b_so_valid", 6'(so_valid_b), 6'd0);
        rst_n = 1'b1;
        #2;
        check1("rst/load_ready",   6'(load_ready_a), 6'd1);
        check1("rst/b_load_ready", 6'(load_ready_b), 6'd1);

        // 2. Single MSB-first word, looped into the receiver.
        sendWord("single", 6'b101001);
        idleCycles("single", 7);
        check1("single/rx_s", rx_s, 6'b101001);

        // 3. Back-to-back words with load_valid held high.
        sendWord("b2b_w0", 6'b111000);
        sendWord("b2b_w1", 6'b010101);
        idleCycles("b2b", 8);

        // 4. Load attempt mid-frame at bit 2 must be refused.
        sendWord("midload", 6'b110100);
        idleCycles("midload", 2);
        applyStimulus("midload_v", 1'b1, 6'b000000, acc);
        check1("midload/refused", 6'(acc), 6'd0);
        applyStimulus("midload_v", 1'b1, 6'b000000, acc);
        idleCycles("midload", 4);

        // 5. Asynchronous reset during bit 3, then a clean reload.
        sendWord("midrst", 6'b100110);
        idleCycles("midrst", 4);
        #2;
        rst_n        = 1'b0;
        load_valid_a = 1'b0;
        #1;
        check1("midrst/so",       6'(so_a),       6'd0);
        check1("midrst/so_valid", 6'(so_valid_a), 6'd0);
        check1("midrst/busy",     6'(busy_a),     6'd0);
        check1("midrst/last",     6'(last_a),     6'd0);
        exp_bit_q.delete();
        exp_last_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        sendWord("reload", 6'b110011);
        idleCycles("reload", 8);

        // 6. LSB-first instance.
        sel_b = 1'b1;
        sendWord("lsb", 6'b101001);
        idleCycles("lsb", 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
